// File: rtl/vc_demux_buffer.sv
// vc_demux_buffer: steers incoming words into two per-VC FIFOs with occupancy flags,
// registered pop outputs, registered backpressure and sticky overflow error.
module vc_demux_buffer #(
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3,
    parameter int AE_THRESH = 1
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic [4:0] data_in,
    input  logic       valid_in,
    input  logic       pop_vc0,
    input  logic       pop_vc1,
    output logic [3:0] data_out_vc0,
    output logic [3:0] data_out_vc1,
    output logic       valid_out_vc0,
    output logic       valid_out_vc1,
    output logic       empty_vc0,
    output logic       empty_vc1,
    output logic       full_vc0,
    output logic       full_vc1,
    output logic       almost_full_vc0,
    output logic       almost_full_vc1,
    output logic       almost_empty_vc0,
    output logic       almost_empty_vc1,
    output logic       pause,
    output logic       error
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] AF_LVL   = AF_THRESH[AW:0];
    localparam logic [AW:0] AE_LVL   = AE_THRESH[AW:0];

    logic [1:0] popReq;
    assign popReq = {pop_vc1, pop_vc0};

    genvar v;
    generate
        for (v = 0; v < 2; v++) begin : gVc
            logic [3:0]    mem [DEPTH];
            logic [AW-1:0] wrPtr;
            logic [AW-1:0] rdPtr;
            logic [AW:0]   count;
            logic [3:0]    dataOut;
            logic          validOut;
            logic          pushReq;
            logic          pushOk;
            logic          popOk;
            logic          drop;
            logic          empty;
            logic          full;
            logic          almostFull;
            logic          almostEmpty;
            always_comb begin
                popOk       = popReq[v] && count != '0;
                pushReq     = valid_in && data_in[4] == 1'(v);
                // a full FIFO still takes a push when a pop frees a slot this cycle
                pushOk      = pushReq && (count != FULL_CNT || popOk);
                drop        = pushReq && !pushOk;
                empty       = count == '0;
                full        = count == FULL_CNT;
                almostFull  = count >= AF_LVL;
                almostEmpty = count <= AE_LVL;
            end
            always_ff @(posedge clk)
                if (pushOk) mem[wrPtr] <= data_in[3:0];
            always_ff @(posedge clk or posedge reset_L) begin
                if (reset_L) begin
                    wrPtr    <= '0;
                    rdPtr    <= '0;
                    count    <= '0;
                    dataOut  <= '0;
                    validOut <= 1'b0;
                end else begin
                    wrPtr    <= pushOk ? wrPtr + AW'(1) : wrPtr;
                    rdPtr    <= popOk ? rdPtr + AW'(1) : rdPtr;
                    count    <= (pushOk && !popOk) ? count + (AW+1)'(1) :
                                (popOk && !pushOk) ? count - (AW+1)'(1) : count;
                    dataOut  <= popOk ? mem[rdPtr] : dataOut;
                    validOut <= popOk;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) begin
            pause <= 1'b0;
            error <= 1'b0;
        end else begin
            pause <= gVc[0].almostFull | gVc[1].almostFull;
            error <= error | gVc[0].drop | gVc[1].drop;
        end
    end

    assign data_out_vc0     = gVc[0].dataOut;
    assign data_out_vc1     = gVc[1].dataOut;
    assign valid_out_vc0    = gVc[0].validOut;
    assign valid_out_vc1    = gVc[1].validOut;
    assign empty_vc0        = gVc[0].empty;
    assign empty_vc1        = gVc[1].empty;
    assign full_vc0         = gVc[0].full;
    assign full_vc1         = gVc[1].full;
    assign almost_full_vc0  = gVc[0].almostFull;
    assign almost_full_vc1  = gVc[1].almostFull;
    assign almost_empty_vc0 = gVc[0].almostEmpty;
    assign almost_empty_vc1 = gVc[1].almostEmpty;
endmodule

// File: doc/vc_demux_buffer.md
VC_DEMUX_BUFFER -- requirements
Module: vc_demux_buffer

Interface
REQ-001 Parameter DEPTH, default 4: entries per VC FIFO; power of two, at least 2.
REQ-002 Parameter AF_THRESH, default 3: almost_full level, 1 <= AF_THRESH <= DEPTH.
REQ-003 Parameter AE_THRESH, default 1: almost_empty level, 0 <= AE_THRESH < DEPTH.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_L  input  1  asynchronous, active-high reset; 1 = reset.
REQ-006 data_in  input  5  incoming word {vc, payload[3:0]}; bit 4 = VC id (0 = VC0, 1 = VC1).
REQ-007 valid_in  input  1  1 = data_in is a word to push this cycle.
REQ-008 pop_vc0, pop_vc1  input  1 each  reader pop request per VC.
REQ-009 data_out_vc0, data_out_vc1  output  4 each  registered popped payload.
REQ-010 valid_out_vc0, valid_out_vc1  output  1 each  1 = matching data_out holds a word popped last cycle.
REQ-011 empty_vc0/1, full_vc0/1  output  1 each  FIFO occupancy flags.
REQ-012 almost_full_vc0/1, almost_empty_vc0/1  output  1 each  threshold flags.
REQ-013 pause  output  1  registered backpressure to the upstream arbiter.
REQ-014 error  output  1  sticky overflow indication.

Function
REQ-015 Each VC has one independent circular FIFO: DEPTH x 4-bit storage, write pointer, read pointer, and a count of width log2(DEPTH)+1.
REQ-016 Steering: a valid_in word goes to the VC FIFO selected by data_in[4]; only data_in[3:0] is stored.
REQ-017 A push is accepted when count < DEPTH, or when count == DEPTH and a pop to the same VC is accepted in the same cycle.
REQ-018 A push not accepted under REQ-017 drops the word, leaves that FIFO unchanged, and sets error to 1 on the next edge.
REQ-019 A pop is accepted when count > 0. On the next edge, data_out_vcN gets the word at the read pointer and valid_out_vcN = 1.
REQ-020 A pop with count == 0 is ignored: valid_out_vcN = 0 next cycle and data_out_vcN holds its value. There is no read-through of a same-cycle push.
REQ-021 valid_out_vcN = 0 in every cycle after a cycle with no accepted pop on that VC.
REQ-022 Pointers wrap modulo DEPTH.
REQ-023 Count update per edge: +1 for a push only, -1 for a pop only, unchanged for both or neither.
REQ-024 Flags are combinational from count:
- empty: count == 0
- full: count == DEPTH
- almost_full: count >= AF_THRESH
- almost_empty: count <= AE_THRESH
REQ-025 pause is registered: pause(next) = almost_full_vc0 | almost_full_vc1, using pre-edge counts. Latency is one cycle; it deasserts one cycle after both flags clear.
REQ-026 Once set, error stays 1 until reset.
REQ-027 VC0 and VC1 operate concurrently. A push to one VC and pops on both VCs in the same cycle are all legal.

Reset
REQ-028 While reset_L = 1, and asynchronously on its assertion:
- all pointers and counts clear to 0
- data_out_vc0/1 = 0, valid_out_vc0/1 = 0
- pause = 0, error = 0
- full = 0, almost_full = 0
- empty = 1, almost_empty = 1
REQ-029 Reset mid-operation discards all stored words. The first push after reset_L falls lands in entry 0.
REQ-030 Storage array contents need not be cleared on reset; they are never observable before being written.

Verification
REQ-031 Push 0x13, 0x05, 0x1A, then pop_vc1 twice -> data_out_vc1 = 0x3 then 0xA with valid_out_vc1 = 1; empty_vc0 = 0, and VC0 holds 0x5.
REQ-032 Push 5 words to VC0 with DEPTH = 4 -> full_vc0 = 1 after the 4th; 5th dropped; error = 1 and stays 1; count stays 4.
REQ-033 Fill VC0 to 3 -> pause = 1 one cycle after almost_full_vc0 rises. Pop once -> pause = 0 one cycle after almost_full_vc0 falls.
REQ-034 VC0 full, then push VC0 0x7 and pop_vc0 in the same cycle -> push accepted, error stays 0, count stays 4. After wrap, popping 4 words ends with 0x7.
REQ-035 VC1 empty, then push 0x19 and pop_vc1 in the same cycle -> valid_out_vc1 = 0; count_vc1 = 1. Next pop returns 0x9.
REQ-036 Assert reset_L mid-stream with VC0 holding 2 words -> flags return to reset values immediately, with no clock edge needed. After release, push 0x04 then pop -> returns 0x4.
